spike_window_counter: RTL and testbench

- Upstream neighbour of the winner-take-all argmax stage.
- Counts output-layer neuron spikes per class over a programmable inference window.
- At window end, latches one saturating count per class onto a registered bus and pulses done_o; the argmax stage consumes counts_o.
- Single clock domain.

---
 rtl/spike_pkg.sv | 26 ++
 rtl/spike_sat_counter.sv | 36 +++
 rtl/spike_window_counter.sv | 149 ++++++++++++++
 tb/tb_spike_window_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// ============================================================================
//  Module      : spike_pkg
//  Description : Shared constants and FSM state type for the spike window
//                counter and the downstream winner-take-all argmax stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spike_pkg;

    // Default class count and counter width, shared with the argmax stage
    localparam int N_CLASSES_DEF = 10;
    localparam int CNT_W_DEF     = 8;

    // Saturation ceiling of a default-width class counter
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    // Window controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage : spike_pkg

`default_nettype wire

// File: rtl/spike_sat_counter.sv
// ============================================================================
//  Module      : spike_sat_counter
//  Description : Per-class spike counter. Clears on clr, increments on inc,
//                and holds at the all-ones value instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_sat_counter
    import spike_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Count up on each inc, clear takes priority, hold once saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != c_cnt_max)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : spike_sat_counter

`default_nettype wire

// File: rtl/spike_window_counter.sv
// ============================================================================
//  Module      : spike_window_counter
//  Description : Counts output-layer spikes per class over a programmable
//                window and publishes the per-class counts on a registered
//                bus with a one-cycle done pulse.
//                Optional macro SPIKE_EARLY_STOP_EN: end the window as soon
//                as any class counter reaches its saturation value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_window_counter
    import spike_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WIN_W     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [WIN_W-1:0]           window_len_i,
    input  logic [N_CLASSES-1:0]       spike_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [N_CLASSES*CNT_W-1:0] counts_o
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [WIN_W-1:0]           r_timer;
    logic [N_CLASSES*CNT_W-1:0] r_counts;
    logic                       r_done;

    logic [N_CLASSES*CNT_W-1:0] w_cnt;
    logic [N_CLASSES*CNT_W-1:0] w_cnt_nxt;
    logic [WIN_W-1:0]           w_len;
    logic                       w_counting;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_finish;

    assign w_counting = (r_state == COUNT);

    // A zero-length request still samples one cycle
    assign w_len = (window_len_i == '0) ? WIN_W'(1) : window_len_i;

    // One saturating counter per class; w_cnt_nxt is the value including
    // this cycle's spike, so the final sampled cycle can be published
    // without an extra pipeline stage.
    generate
        for (genvar k = 0; k < N_CLASSES; k++) begin : g_class
            spike_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk_i),
                .rst   (rst_i),
                .clr   (w_accept),
                .inc   (w_counting & spike_i[k]),
                .count (w_cnt[k*CNT_W +: CNT_W])
            );

            assign w_cnt_nxt[k*CNT_W +: CNT_W] =
                (spike_i[k] && (w_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                    ? w_cnt[k*CNT_W +: CNT_W] + CNT_W'(1)
                    : w_cnt[k*CNT_W +: CNT_W];
        end
    endgenerate

`ifdef SPIKE_EARLY_STOP_EN
    logic [N_CLASSES-1:0] w_hit;

    // Flag classes whose count reaches the ceiling in this cycle
    generate
        for (genvar k = 0; k < N_CLASSES; k++) begin : g_hit
            assign w_hit[k] = (w_cnt_nxt[k*CNT_W +: CNT_W] == {CNT_W{1'b1}});
        end
    endgenerate

    assign w_last = (r_timer == WIN_W'(1)) || (|w_hit);
`else
    assign w_last = (r_timer == WIN_W'(1));
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks the final sampled cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window timer: loaded on start, counts down once per sampled cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer <= '0;
        end else if (w_accept) begin
            r_timer <= w_len;
        end else if (w_counting) begin
            r_timer <= r_timer - WIN_W'(1);
        end
    end

    // Publish counts and pulse done when a window completes normally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_counts <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_counts <= w_cnt_nxt;
            end
        end
    end

    assign busy_o   = w_counting;
    assign done_o   = r_done;
    assign counts_o = r_counts;

endmodule : spike_window_counter

`default_nettype wire

// File: tb/tb_spike_window_counter.sv
// ============================================================================
//  Module      : tb_spike_window_counter
//  Description : Self-checking bench for spike_window_counter: a table of
//                single windows plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_window_counter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] win_len;
    logic [9:0]  spike;
    logic        busy;
    logic        done;
    logic [79:0] counts;

    int checks = 0;
    int errors = 0;

    spike_window_counter #(
        .N_CLASSES (10),
        .CNT_W     (8),
        .WIN_W     (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abort),
        .window_len_i (win_len),
        .spike_i      (spike),
        .busy_o       (busy),
        .done_o       (done),
        .counts_o     (counts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [9:0] spk;
        int         val;
        int         done_cyc;
    } vec_t;

    vec_t vecs[6];

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] exp_counts(input logic [9:0] spk, input int val);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) begin
            if (spk[k]) r[k*8 +: 8] = 8'(val);
        end
        return r;
    endfunction

    // Count done pulses over n cycles
    task automatic count_dones(input int n, output int nd);
        nd = 0;
        for (int c = 0; c < n; c++) begin
            if (done) nd++;
            step();
        end
    endtask

    int done_cyc;
    int nd;

    initial begin
        vecs[0] = '{len: 4,   spk: 10'b0000000101, val: 4,   done_cyc: 5};
        vecs[1] = '{len: 0,   spk: 10'b0000000010, val: 1,   done_cyc: 2};
        vecs[2] = '{len: 3,   spk: 10'b0000000000, val: 0,   done_cyc: 4};
        vecs[3] = '{len: 1,   spk: 10'b1111111111, val: 1,   done_cyc: 2};
`ifdef SPIKE_EARLY_STOP_EN
        vecs[4] = '{len: 300, spk: 10'b1000000000, val: 255, done_cyc: 256};
`else
        vecs[4] = '{len: 300, spk: 10'b1000000000, val: 255, done_cyc: 301};
`endif
        vecs[5] = '{len: 7,   spk: 10'b1000000000, val: 7,   done_cyc: 8};

        rst = 1'b1; start = 1'b0; abort = 1'b0; win_len = '0; spike = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_counts", counts, '0);

        // Table: start in cycle 0 with every class spiking (must be ignored)
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; win_len = 16'(vecs[i].len); spike = 10'h3FF;
            step();
            start = 1'b0; spike = vecs[i].spk;
            chk($sformatf("v%0d_busy_c1", i), busy, 1);
            done_cyc = -1;
            for (int c = 1; c <= 400; c++) begin
                if (done) begin
                    done_cyc = c;
                    break;
                end
                step();
            end
            chk($sformatf("v%0d_done_cycle", i), 80'(done_cyc), 80'(vecs[i].done_cyc));
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            chk($sformatf("v%0d_counts", i), counts, exp_counts(vecs[i].spk, vecs[i].val));
            spike = '0;
            step();
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
        end

        // Reset in the middle of a window
        start = 1'b1; win_len = 16'd20; spike = 10'h001;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_counts", counts, '0);
        count_dones(30, nd);
        chk("midrst_no_done", 80'(nd), 0);

        // Back-to-back start in the done cycle, second window aborted
        start = 1'b1; win_len = 16'd4; spike = 10'h3FF;
        step();
        start = 1'b0; spike = 10'b0000000101;
        repeat (4) step();
        chk("b2b_first_done", done, 1);
        start = 1'b1; win_len = 16'd10; spike = 10'h0F0;
        step();
        start = 1'b0;
        chk("b2b_busy_next", busy, 1);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        count_dones(20, nd);
        chk("abort_no_done", 80'(nd), 0);
        chk("abort_counts_kept", counts, exp_counts(10'b0000000101, 4));

        // start pulsed during COUNT is ignored
        start = 1'b1; win_len = 16'd6; spike = 10'h3FF;
        step();
        start = 1'b0; spike = 10'b0000001000;
        step();
        step();
        start = 1'b1; win_len = 16'd2;
        step();
        start = 1'b0;
        done_cyc = -1;
        for (int c = 4; c <= 40; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            step();
        end
        chk("ignstart_done_cycle", 80'(done_cyc), 7);
        chk("ignstart_counts", counts, exp_counts(10'b0000001000, 6));
        spike = '0;
        step();
        count_dones(15, nd);
        chk("ignstart_single_done", 80'(nd), 0);

        // Abort coinciding with the last sampled cycle
        start = 1'b1; win_len = 16'd5; spike = '0;
        step();
        spike = 10'h100; start = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0; spike = '0;
        chk("abortlast_busy", busy, 0);
        count_dones(10, nd);
        chk("abortlast_no_done", 80'(nd), 0);
        chk("abortlast_counts_kept", counts, exp_counts(10'b0000001000, 6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spike_window_counter

`default_nettype wire
